// File: rtl/seg7_pkg.sv
// Shared types and segment codes for the 3-digit counter display.
// Segment bytes are {dp,g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

    localparam int NUM_DIGITS = 3;

    typedef logic [3:0] bcd_t;
    typedef logic [1:0] digit_sel_t;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/segment7_counter_if.sv
// Display-side bundle: direction control in, digit enables and segments out.
// The counter uses the slave view, whoever drives REVERSE uses master.
interface segment7_counter_if;

    logic       REVERSE;
    logic       D1;
    logic       D2;
    logic       D3;
    logic [7:0] DOUT;

    modport master (
        output REVERSE,
        input  D1,
        input  D2,
        input  D3,
        input  DOUT
    );

    modport slave (
        input  REVERSE,
        output D1,
        output D2,
        output D3,
        output DOUT
    );

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder.
// Codes 10..15 never occur in the counter and decode to blank.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  bcd_t       bcd,
    output logic [7:0] seg
);

    // Segment lookup for one decimal digit.
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/segment7_counter.sv
// Free-running 000..999 BCD up/down counter on a multiplexed 3-digit display.
// Outputs are registered, so they show the state from one cycle earlier.
module segment7_counter
    import seg7_pkg::*;
#(
    parameter int TICK_DIV = 40_000_000,
    parameter int SCAN_DIV = 40_000
) (
    input  logic               CLK,
    input  logic               RESET,
    segment7_counter_if.slave  disp
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);

    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] scan_cnt;
    logic          tick;
    logic          scan;

    bcd_t       ones;
    bcd_t       tens;
    bcd_t       hunds;
    bcd_t       ones_nx;
    bcd_t       tens_nx;
    bcd_t       hunds_nx;
    digit_sel_t sel;
    bcd_t       cur_digit;
    logic [7:0] seg_code;
    logic [2:0] en_q;
    logic [7:0] dout_q;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));
    assign scan = (scan_cnt == SW'(SCAN_DIV - 1));

    // Both prescalers wrap at their terminal count.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tick_cnt <= '0;
            scan_cnt <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            scan_cnt <= scan ? '0 : scan_cnt + SW'(1);
        end
    end

    // Next BCD value: ripple carry on count-up, ripple borrow on count-down.
    always_comb begin
        ones_nx  = ones;
        tens_nx  = tens;
        hunds_nx = hunds;
        if (!disp.REVERSE) begin
            ones_nx = (ones == 4'd9) ? 4'd0 : ones + 4'd1;
            if (ones == 4'd9) begin
                tens_nx = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
                if (tens == 4'd9)
                    hunds_nx = (hunds == 4'd9) ? 4'd0 : hunds + 4'd1;
            end
        end else begin
            ones_nx = (ones == 4'd0) ? 4'd9 : ones - 4'd1;
            if (ones == 4'd0) begin
                tens_nx = (tens == 4'd0) ? 4'd9 : tens - 4'd1;
                if (tens == 4'd0)
                    hunds_nx = (hunds == 4'd0) ? 4'd9 : hunds - 4'd1;
            end
        end
    end

    // Count state only moves on a tick, so REVERSE matters only then.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ones  <= '0;
            tens  <= '0;
            hunds <= '0;
        end else if (tick) begin
            ones  <= ones_nx;
            tens  <= tens_nx;
            hunds <= hunds_nx;
        end
    end

    // Scan index cycles ones -> tens -> hundreds.
    always_ff @(posedge CLK) begin
        if (RESET)
            sel <= '0;
        else if (scan)
            sel <= (sel == digit_sel_t'(NUM_DIGITS - 1)) ? '0 : sel + 2'd1;
    end

    // Pick the digit being scanned.
    always_comb begin
        cur_digit = hunds;
        case (sel)
            2'd0:    cur_digit = ones;
            2'd1:    cur_digit = tens;
            default: cur_digit = hunds;
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd (cur_digit),
        .seg (seg_code)
    );

    // Register enables and segments together so they never disagree.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            en_q   <= 3'b001;
            dout_q <= SEG_0;
        end else begin
            en_q   <= 3'b001 << sel;
            dout_q <= seg_code;
        end
    end

    assign disp.D1   = en_q[0];
    assign disp.D2   = en_q[1];
    assign disp.D3   = en_q[2];
    assign disp.DOUT = dout_q;

endmodule

// File: tb/tb_segment7_counter.sv
// Directed bench for segment7_counter with a cycle-level reference model
// feeding an expected-output queue.
module tb_segment7_counter;

    localparam int TD = 4;
    localparam int SD = 2;

    typedef struct packed {
        logic [2:0] en;
        logic [7:0] dout;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    int m_tick;
    int m_scan;
    int m_sel;
    int m_count;

    logic [7:0] seg_tab [10];
    exp_t       sb [$];

    segment7_counter_if bus ();

    segment7_counter #(
        .TICK_DIV (TD),
        .SCAN_DIV (SD)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .disp  (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input string tag);
        exp_t e;
        exp_t x;
        int   dg;
        logic [2:0] en_obs;
        if (rst) begin
            e.en   = 3'b001;
            e.dout = 8'h3F;
        end else begin
            case (m_sel)
                0:       dg = m_count % 10;
                1:       dg = (m_count / 10) % 10;
                default: dg = m_count / 100;
            endcase
            e.en   = 3'(1 << m_sel);
            e.dout = seg_tab[dg];
        end
        sb.push_back(e);
        if (rst) begin
            m_tick  = 0;
            m_scan  = 0;
            m_sel   = 0;
            m_count = 0;
        end else begin
            if (m_tick == TD - 1) begin
                m_tick  = 0;
                m_count = bus.REVERSE ? (m_count + 999) % 1000
                                      : (m_count + 1) % 1000;
            end else begin
                m_tick++;
            end
            if (m_scan == SD - 1) begin
                m_scan = 0;
                m_sel  = (m_sel + 1) % 3;
            end else begin
                m_scan++;
            end
        end
        @(posedge clk);
        #1;
        x = sb.pop_front();
        en_obs = {bus.D3, bus.D2, bus.D1};
        checks++;
        assert (en_obs === x.en) else begin
            errors++;
            $error("FAIL %s enables: got %b expected %b", tag, en_obs, x.en);
        end
        checks++;
        assert (bus.DOUT === x.dout) else begin
            errors++;
            $error("FAIL %s dout: got %h expected %h", tag, bus.DOUT, x.dout);
        end
        checks++;
        assert ($onehot(en_obs)) else begin
            errors++;
            $error("FAIL %s onehot: got %b expected one-hot", tag, en_obs);
        end
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) step(tag);
    endtask

    // Checks the segments against a per-phase constant.
    task automatic phase_chk(input string tag, input logic [7:0] v1,
                             input logic [7:0] v2, input logic [7:0] v3);
        logic [7:0] want;
        want = bus.D1 ? v1 : (bus.D2 ? v2 : v3);
        checks++;
        assert (bus.DOUT === want) else begin
            errors++;
            $error("FAIL %s phase: got %h expected %h", tag, bus.DOUT, want);
        end
    endtask

    task automatic en_chk(input string tag, input logic [2:0] want);
        logic [2:0] got;
        got = {bus.D3, bus.D2, bus.D1};
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s en: got %b expected %b", tag, got, want);
        end
    endtask

    task automatic dout_chk(input string tag, input logic [7:0] want);
        checks++;
        assert (bus.DOUT === want) else begin
            errors++;
            $error("FAIL %s dout: got %h expected %h", tag, bus.DOUT, want);
        end
    endtask

    initial begin
        seg_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                    8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
        m_tick  = 0;
        m_scan  = 0;
        m_sel   = 0;
        m_count = 0;

        rst = 1'b1;
        bus.REVERSE = 1'b0;
        run(3, "reset");
        en_chk("reset_en", 3'b001);
        dout_chk("reset_dout", 8'h3F);

        rst = 1'b0;
        run(40, "up10");
        for (int i = 0; i < 8; i++) begin
            step("cnt010");
            phase_chk("cnt010", 8'h3F, 8'h06, 8'h3F);
        end

        bus.REVERSE = 1'b1;
        run(2, "rev_between");
        bus.REVERSE = 1'b0;
        run(6, "rev_between");

        rst = 1'b1;
        step("wrap_rst");
        rst = 1'b0;
        run(3996, "to999");
        for (int i = 0; i < 4; i++) begin
            step("at999");
            phase_chk("at999", 8'h6F, 8'h6F, 8'h6F);
        end
        for (int i = 0; i < 4; i++) begin
            step("wrap000");
            phase_chk("wrap000", 8'h3F, 8'h3F, 8'h3F);
        end

        rst = 1'b1;
        step("down_rst");
        rst = 1'b0;
        bus.REVERSE = 1'b1;
        run(4, "down");
        for (int i = 0; i < 4; i++) begin
            step("down999");
            phase_chk("down999", 8'h6F, 8'h6F, 8'h6F);
        end

        rst = 1'b1;
        bus.REVERSE = 1'b0;
        step("scan_rst");
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step("scan");
            en_chk("scan_seq", 3'(3'b001 << ((i / 2) % 3)));
        end

        rst = 1'b1;
        step("mid_rst0");
        rst = 1'b0;
        run(22, "to005");
        step("at005");
        en_chk("at005_en", 3'b100);
        dout_chk("at005_dout", 8'h3F);
        rst = 1'b1;
        step("mid_rst");
        en_chk("mid_rst_en", 3'b001);
        dout_chk("mid_rst_dout", 8'h3F);
        rst = 1'b0;
        run(7, "restart");
        step("restart");
        en_chk("restart_en", 3'b001);
        dout_chk("restart_dout", 8'h06);
        run(6, "tail");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
